// File: rtl/sccb_arbiter_if.sv
// Bundles the two requester ports and the sccb_ctrl command port of sccb_arbiter.
// Handshake: a requester holds req (with we/addr/wdata valid at the granting edge) until its one-cycle ack;
// toward sccb_ctrl, rreq/wreq are levels held until the one-cycle com_done pulse (data_read valid with it).
interface sccb_arbiter_if;
  logic       init_done;
  logic       req0;
  logic       we0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic       err0;
  logic [7:0] rdata0;
  logic       req1;
  logic       we1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic       err1;
  logic [7:0] rdata1;
  logic       rreq;
  logic       wreq;
  logic [7:0] addr_rw;
  logic [7:0] data_write;
  logic       com_done;
  logic [7:0] data_read;
  logic       busy;
  logic       grant;
  logic [1:0] state_dbg;

  modport slave (
    input  init_done, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, com_done, data_read,
    output ack0, err0, rdata0, ack1, err1, rdata1, rreq, wreq, addr_rw, data_write, busy, grant,
           state_dbg
  );

  modport master (
    output init_done, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, com_done, data_read,
    input  ack0, err0, rdata0, ack1, err1, rdata1, rreq, wreq, addr_rw, data_write, busy, grant,
           state_dbg
  );
endinterface

// File: rtl/sccb_arbiter.sv
// Two-port round-robin arbiter in front of sccb_ctrl: one transaction at a time,
// a bus-idle gap after every completion, and a completion timeout that aborts with err.
module sccb_arbiter #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic          clk25,
  input  logic          RESETn,
  sccb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] tmo_cnt;
  logic [7:0]  gap_cnt;
  logic        lat_we;
  logic [7:0]  lat_addr;
  logic [7:0]  lat_wdata;
  logic        grant_r;
  logic        last_grant;
  logic        err_r;
  logic [7:0]  rdata0_r;
  logic [7:0]  rdata1_r;
  logic        any_req;
  logic        pick;
  logic        tmo_hit;
  logic        gap_end;
  logic        in_wait;
  logic        in_done;

  assign any_req = bus.init_done & (bus.req0 | bus.req1);
  // On a tie the port that did not own the previous transaction wins.
  assign pick    = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
  assign gap_end = (gap_cnt == 8'(GAP_CYCLES - 1));

  always_ff @(posedge clk25 or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (any_req) state_next = S_WAIT;
      S_WAIT:  if (bus.com_done || tmo_hit) state_next = S_DONE;
      S_DONE:  state_next = S_GAP;
      S_GAP:   if (gap_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      grant_r    <= 1'b0;
      last_grant <= 1'b1;
      err_r      <= 1'b0;
      rdata0_r   <= '0;
      rdata1_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          gap_cnt <= '0;
          if (any_req) begin
            grant_r    <= pick;
            last_grant <= pick;
            lat_we     <= pick ? bus.we1    : bus.we0;
            lat_addr   <= pick ? bus.addr1  : bus.addr0;
            lat_wdata  <= pick ? bus.wdata1 : bus.wdata0;
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // com_done takes priority over a timeout expiring in the same cycle.
          if (bus.com_done) begin
            err_r <= 1'b0;
            if (!lat_we) begin
              if (grant_r) rdata1_r <= bus.data_read;
              else         rdata0_r <= bus.data_read;
            end
          end else if (tmo_hit) begin
            err_r <= 1'b1;
          end
        end
        S_DONE:  gap_cnt <= '0;
        S_GAP:   gap_cnt <= gap_cnt + 8'd1;
        default: gap_cnt <= '0;
      endcase
    end
  end

  assign in_wait        = (state == S_WAIT);
  assign in_done        = (state == S_DONE);
  assign bus.wreq       = in_wait & lat_we;
  assign bus.rreq       = in_wait & ~lat_we;
  assign bus.addr_rw    = lat_addr;
  assign bus.data_write = lat_wdata;
  assign bus.ack0       = in_done & ~grant_r;
  assign bus.ack1       = in_done & grant_r;
  assign bus.err0       = in_done & ~grant_r & err_r;
  assign bus.err1       = in_done & grant_r & err_r;
  assign bus.rdata0     = rdata0_r;
  assign bus.rdata1     = rdata1_r;
  assign bus.busy       = (state != S_IDLE);
  assign bus.grant      = grant_r;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: the bench plays both requesters and sccb_ctrl,
// predicting winners, WAIT lengths, errors and read data from the arbitration rules.
module tb_sccb_arbiter;
  localparam int GAP = 16;
  localparam int TMO = 100;

  logic clk25;
  logic RESETn;
  int   cyc;
  int   ack_cyc;
  int   vectors;
  int   miscompares;
  int   lat;

  // Reference model state
  logic        pend[2];
  logic        p_we[2];
  logic [7:0]  p_addr[2];
  logic [7:0]  p_wdata[2];
  logic [7:0]  exp_rdata[2];
  int          exp_last;
  logic [17:0] exp_q[$];

  sccb_arbiter_if bus();

  sccb_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk25  (clk25),
    .RESETn (RESETn),
    .bus    (bus)
  );

  // Clock / reset block
  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;
  always @(posedge clk25 or negedge RESETn) begin
    if (!RESETn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? bus.err1 : bus.err0;
  endfunction

  // Driver tasks
  task automatic drive_port(input int p, input logic rq, input logic we, input logic [7:0] a,
                            input logic [7:0] d);
    if (p == 0) begin
      bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic raise(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
    drive_port(p, 1'b1, we, a, d);
  endtask

  task automatic raise_rand(input int p);
    raise(p, 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Serves one transaction as sccb_ctrl; delay = WAIT cycle index of com_done, -1 for none.
  task automatic serve(input int delay, input logic [7:0] rd, input logic chk_gap,
                       input logic drop_init, output int lat_o);
    int w;
    int k;
    int p;
    int exp_len;
    logic exp_err;
    logic [17:0] exp_t;

    p = (pend[0] && pend[1]) ? ((exp_last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
    exp_q.push_back({p[0], p_we[p], p_addr[p], p_wdata[p]});
    w = 0;
    while (!(bus.rreq || bus.wreq) && w < 300) begin
      @(negedge clk25);
      w++;
    end
    lat_o = w;
    exp_t = exp_q.pop_front();
    if (!(bus.rreq || bus.wreq)) begin
      check("grant_seen", 32'(bus.rreq | bus.wreq), 32'(1));
      return;
    end
    check("grant_port", 32'(bus.grant), 32'(exp_t[17]));
    check("wreq", 32'(bus.wreq), 32'(exp_t[16]));
    check("rreq", 32'(bus.rreq), 32'(!exp_t[16]));
    check("busy_wait", 32'(bus.busy), 32'(1));
    if (chk_gap) check("gap_len", 32'(cyc - ack_cyc), 32'(GAP + 2));
    if (drop_init) bus.init_done = 1'b0;
    drive_port(p, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));

    k = 0;
    forever begin
      check("wait_stable", {16'd0, bus.addr_rw, bus.data_write}, {16'd0, exp_t[15:0]});
      bus.com_done  = (k == delay);
      bus.data_read = (k == delay) ? rd : 8'($urandom);
      @(negedge clk25);
      bus.com_done = 1'b0;
      if (!(bus.rreq || bus.wreq) || k >= 400) break;
      k++;
    end

    exp_len = (delay >= 0 && delay < TMO) ? delay + 1 : TMO;
    exp_err = !(delay >= 0 && delay < TMO);
    if (!exp_t[16] && !exp_err) exp_rdata[p] = rd;
    check("wait_len", 32'(k + 1), 32'(exp_len));
    check("ack_owner", 32'(ack_of(p)), 32'(1));
    check("err_owner", 32'(err_of(p)), 32'(exp_err));
    check("ack_other", 32'(ack_of(1 - p)), 32'(0));
    check("err_other", 32'(err_of(1 - p)), 32'(0));
    check("rdata0", 32'(bus.rdata0), 32'(exp_rdata[0]));
    check("rdata1", 32'(bus.rdata1), 32'(exp_rdata[1]));
    ack_cyc  = cyc;
    exp_last = p;
    pend[p]  = 1'b0;
    drive_port(p, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));

    // A stray com_done while in DONE must be ignored.
    bus.com_done  = 1'b1;
    bus.data_read = 8'($urandom);
    @(negedge clk25);
    bus.com_done = 1'b0;
    check("ack_err_clear", {28'd0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
    check("gap_idle_bus", {30'd0, bus.rreq, bus.wreq}, 32'd0);
    check("busy_gap", 32'(bus.busy), 32'(1));
  endtask

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -1;
    if (r == 1) return TMO - 1;
    if (r == 2) return TMO - 2;
    return int'($urandom_range(0, 50));
  endfunction

  initial begin
    int nserve;
    int mask;
    vectors = 0; miscompares = 0; ack_cyc = 0;
    exp_last = 1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; exp_rdata[i] = 8'd0;
      drive_port(i, 1'b0, 1'b0, 8'd0, 8'd0);
    end
    bus.init_done = 1'b0; bus.com_done = 1'b0; bus.data_read = 8'd0;
    RESETn = 1'b0;
    repeat (3) @(negedge clk25);

    // Reset state
    check("rst_ctrl", {24'd0, bus.rreq, bus.wreq, bus.ack0, bus.ack1, bus.err0, bus.err1,
                       bus.busy, bus.grant}, 32'd0);
    check("rst_rdata", {16'd0, bus.rdata0, bus.rdata1}, 32'd0);
    check("rst_cmd", {16'd0, bus.addr_rw, bus.data_write}, 32'd0);
    RESETn = 1'b1;

    // No grant while init_done is low
    raise(0, 1'b1, 8'h12, 8'h80);
    repeat (100) begin
      @(negedge clk25);
      check("no_grant_init", {29'd0, bus.busy, bus.rreq, bus.wreq}, 32'd0);
    end
    bus.init_done = 1'b1;
    serve(40, 8'h00, 1'b0, 1'b0, lat);
    check("init_latency", 32'(lat), 32'(1));

    // Port 1 read
    raise(1, 1'b0, 8'h0A, 8'($urandom));
    serve(int'($urandom_range(0, 60)), 8'h76, 1'b1, 1'b0, lat);
    check("rdata1_read", 32'(bus.rdata1), 32'h76);
    check("rdata0_kept", 32'(bus.rdata0), 32'h00);

    // Contending requesters alternate
    raise_rand(0);
    raise_rand(1);
    for (int i = 0; i < 4; i++) begin
      serve(int'($urandom_range(0, 30)), 8'($urandom), 1'b1, 1'b0, lat);
      check("alt_order", 32'(bus.grant), 32'(i % 2));
      if (i < 2) raise_rand(exp_last);
    end

    // Timeout, then com_done on the last WAIT cycle
    raise(0, 1'b0, 8'h33, 8'h00);
    serve(-1, 8'h00, 1'b1, 1'b0, lat);
    raise(0, 1'b0, 8'h34, 8'h00);
    serve(TMO - 1, 8'h5A, 1'b1, 1'b0, lat);

    // Randomized traffic
    for (int it = 0; it < 10; it++) begin
      mask = int'($urandom_range(1, 3));
      nserve = 0;
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          raise_rand(p);
          nserve++;
        end
      end
      for (int s = 0; s < nserve; s++) serve(rand_delay(), 8'($urandom), 1'b1, 1'b0, lat);
    end

    // init_done falls mid-transaction: completes, then no new grant until it returns
    raise_rand(0);
    serve(int'($urandom_range(0, 30)), 8'($urandom), 1'b1, 1'b1, lat);
    raise_rand(1);
    repeat (40) begin
      @(negedge clk25);
      check("hold_init_low", {30'd0, bus.rreq, bus.wreq}, 32'd0);
    end
    bus.init_done = 1'b1;
    serve(int'($urandom_range(0, 30)), 8'($urandom), 1'b0, 1'b0, lat);
    check("reinit_latency", 32'(lat), 32'(1));

    // Asynchronous reset in the middle of WAIT
    raise(0, 1'b1, 8'h44, 8'h55);
    for (int w = 0; w < 60 && !(bus.rreq || bus.wreq); w++) @(negedge clk25);
    check("pre_reset_wait", 32'(bus.wreq), 32'(1));
    @(posedge clk25);
    #2;
    RESETn = 1'b0;
    #1;
    check("async_reset", {27'd0, bus.rreq, bus.wreq, bus.ack0, bus.ack1, bus.busy}, 32'd0);
    exp_last = 1;
    exp_rdata[0] = 8'd0;
    exp_rdata[1] = 8'd0;
    raise_rand(1);
    @(negedge clk25);
    RESETn = 1'b1;
    serve(int'($urandom_range(0, 30)), 8'($urandom), 1'b0, 1'b0, lat);
    check("tie_after_reset", 32'(bus.grant), 32'(0));
    serve(int'($urandom_range(0, 30)), 8'($urandom), 1'b1, 1'b0, lat);
    check("second_after_reset", 32'(bus.grant), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
